// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (MEM) requesters.
// Optional ARB_PERF_CNT_EN adds per-requester stall-cycle counters.
module imem_dmem_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_DM_STREAK = 4,
    parameter int unsigned TIMEOUT       = 16
`ifdef ARB_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W         = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_timeout
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  if_wait_cnt,
    output logic [CNT_W-1:0]  dm_wait_cnt
`endif
);

    localparam int unsigned WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [STREAK_W-1:0] dm_streak;
    logic                grant_if;
    logic                grant_dm;
    logic                finish;
    logic                timeout_hit;

    // Arbitration, completion detection and combinational handshakes.
    always_comb begin
        state_next  = state;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;
        finish      = 1'b0;
        timeout_hit = 1'b0;
        if_rvalid   = 1'b0;
        dm_done     = 1'b0;
        if_rdata    = '0;
        dm_rdata    = '0;
        case (state)
            IDLE: begin
                if (dm_req && (!if_req || (dm_streak < STREAK_W'(MAX_DM_STREAK)))) begin
                    grant_dm   = 1'b1;
                    state_next = BUSY_DM;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                // An ack on the last wait cycle wins over the timeout.
                timeout_hit = !mem_ack && (wait_cnt == WAIT_W'(TIMEOUT - 1));
                finish      = mem_ack || timeout_hit;
                if (finish) begin
                    state_next = IDLE;
                end
                if (state == BUSY_IF) begin
                    if_rvalid = finish;
                    if_rdata  = mem_ack ? mem_rdata : '0;
                end else begin
                    dm_done  = finish;
                    dm_rdata = mem_ack ? mem_rdata : '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign if_stall = if_req & ~if_rvalid;
    assign dm_stall = dm_req & ~dm_done;

    // State, memory port, wait counter, streak and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wait_cnt    <= '0;
            dm_streak   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_next;

            if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (finish) begin
                mem_req <= 1'b0;
            end

            if (finish) begin
                wait_cnt <= '0;
            end else if (state != IDLE) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            // Streak only grows while IF is actually being held off.
            if (grant_if) begin
                dm_streak <= '0;
            end else if (grant_dm) begin
                if (!if_req) begin
                    dm_streak <= '0;
                end else if (dm_streak != STREAK_W'(MAX_DM_STREAK)) begin
                    dm_streak <= dm_streak + STREAK_W'(1);
                end
            end

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Saturating stall-cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_wait_cnt <= '0;
            dm_wait_cnt <= '0;
        end else begin
            if (if_stall && !(&if_wait_cnt)) begin
                if_wait_cnt <= if_wait_cnt + CNT_W'(1);
            end
            if (dm_stall && !(&dm_wait_cnt)) begin
                dm_wait_cnt <= dm_wait_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed self-checking bench for imem_dmem_arbiter; drives mem_ack by hand.
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err_timeout;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_wait_cnt;
    logic [31:0] dm_wait_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    imem_dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err_timeout(err_timeout)
`ifdef ARB_PERF_CNT_EN
        , .if_wait_cnt(if_wait_cnt), .dm_wait_cnt(dm_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %0h want 0", mem_we); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h want 0", err_timeout); end
        n_cmp++; if ({if_rvalid, dm_done, if_stall, dm_stall} !== 4'b0) begin
            n_fail++; $display("FAIL reset_handshake: got %b want 0000", {if_rvalid, dm_done, if_stall, dm_stall}); end
        step();
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle_req: got %0h want 0", mem_req); end
    endtask

    task automatic test_fetch();
        step();
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        n_cmp++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall0: got %0h want 1", if_stall); end
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_before_grant: got %0h want 0", mem_req); end
        step();
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            n_fail++; $display("FAIL fetch_mem_port: got req=%0h we=%0h addr=%h want 1 0 00000100", mem_req, mem_we, mem_addr); end
        step();
        n_cmp++; if ({if_rvalid, if_stall} !== 2'b01) begin
            n_fail++; $display("FAIL fetch_wait: got rvalid,stall=%b want 01", {if_rvalid, if_stall}); end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        #1;
        n_cmp++; if ({if_rvalid, if_stall, if_rdata} !== {1'b1, 1'b0, 32'h00500093}) begin
            n_fail++; $display("FAIL fetch_done: got rvalid=%0h stall=%0h rdata=%h want 1 0 00500093", if_rvalid, if_stall, if_rdata); end
        step();
        mem_ack = 1'b0; if_req = 1'b0;
        #1;
        n_cmp++; if ({mem_req, if_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL fetch_release: got req,rvalid=%b want 00", {mem_req, if_rvalid}); end
`ifdef ARB_PERF_CNT_EN
        n_cmp++; if (if_wait_cnt !== 32'd3) begin n_fail++; $display("FAIL fetch_perf: got %0d want 3", if_wait_cnt); end
`endif
    endtask

    task automatic test_priority();
        step();
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_wdata = 32'h0;
        step();
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h2000}) begin
            n_fail++; $display("FAIL prio_dm_first: got req=%0h we=%0h addr=%h want 1 0 00002000", mem_req, mem_we, mem_addr); end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        #1;
        n_cmp++; if ({dm_done, if_rvalid, if_stall, dm_rdata} !== {1'b1, 1'b0, 1'b1, 32'h11112222}) begin
            n_fail++; $display("FAIL prio_dm_done: got done=%0h rvalid=%0h istall=%0h rdata=%h want 1 0 1 11112222", dm_done, if_rvalid, if_stall, dm_rdata); end
        step();
        mem_ack = 1'b0; dm_req = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL prio_gap: got %0h want 0", mem_req); end
        step();
        n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h300, 32'h0}) begin
            n_fail++; $display("FAIL prio_if_next: got req=%0h we=%0h addr=%h wdata=%h want 1 0 00000300 0", mem_req, mem_we, mem_addr, mem_wdata); end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h33334444;
        #1;
        n_cmp++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h33334444}) begin
            n_fail++; $display("FAIL prio_if_done: got rvalid=%0h rdata=%h want 1 33334444", if_rvalid, if_rdata); end
        step();
        mem_ack = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_streak();
        logic [5:0] order;
        logic       is_dm;
        order = 6'b101111;
        step();
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'hA5A5A5A5;
        for (int i = 0; i < 6; i++) begin
            is_dm = order[i];
            step();
            n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !==
                         (is_dm ? {1'b1, 1'b1, 32'h3000, 32'hA5A5A5A5} : {1'b1, 1'b0, 32'h400, 32'h0})) begin
                n_fail++; $display("FAIL streak_grant%0d: got we=%0h addr=%h wdata=%h want dm=%0h", i, mem_we, mem_addr, mem_wdata, is_dm); end
            mem_ack = 1'b1; mem_rdata = 32'(i);
            #1;
            n_cmp++; if ({dm_done, if_rvalid} !== {is_dm, ~is_dm}) begin
                n_fail++; $display("FAIL streak_done%0d: got done,rvalid=%b want %b", i, {dm_done, if_rvalid}, {is_dm, ~is_dm}); end
            step();
            mem_ack = 1'b0;
        end
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    endtask

    task automatic test_ack_on_timeout_cycle();
        step();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; mem_rdata = 32'h0;
        step();
        for (int k = 0; k < 15; k++) begin
            n_cmp++; if (dm_done !== 1'b0) begin n_fail++; $display("FAIL late_ack_early%0d: got %0h want 0", k, dm_done); end
            step();
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        n_cmp++; if ({dm_done, dm_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            n_fail++; $display("FAIL late_ack_done: got done=%0h rdata=%h want 1 cafef00d", dm_done, dm_rdata); end
        step();
        mem_ack = 1'b0; dm_req = 1'b0;
        #1;
        n_cmp++; if ({err_timeout, mem_req} !== 2'b00) begin
            n_fail++; $display("FAIL late_ack_noerr: got err,req=%b want 00", {err_timeout, mem_req}); end
    endtask

    task automatic test_timeout();
        step();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
        mem_rdata = 32'h12345678;
        step();
        n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h40, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL tmo_store_port: got req=%0h we=%0h addr=%h wdata=%h want 1 1 00000040 deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
        for (int k = 0; k < 15; k++) begin
            n_cmp++; if ({dm_done, err_timeout} !== 2'b00) begin
                n_fail++; $display("FAIL tmo_wait%0d: got done,err=%b want 00", k, {dm_done, err_timeout}); end
            step();
        end
        n_cmp++; if ({dm_done, dm_rdata} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL tmo_done: got done=%0h rdata=%h want 1 0", dm_done, dm_rdata); end
        step();
        dm_req = 1'b0; dm_we = 1'b0;
        #1;
        n_cmp++; if ({err_timeout, mem_req, dm_done} !== 3'b100) begin
            n_fail++; $display("FAIL tmo_abort: got err,req,done=%b want 100", {err_timeout, mem_req, dm_done}); end
        repeat (3) step();
        n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %0h want 1", err_timeout); end
    endtask

    task automatic test_reset_mid_busy();
        step();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h50;
        step();
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstbusy_granted: got %0h want 1", mem_req); end
        rst = 1'b1;
        step();
        rst = 1'b0; dm_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h77;
        #1;
        n_cmp++; if ({dm_done, if_rvalid, mem_req, err_timeout} !== 4'b0000) begin
            n_fail++; $display("FAIL rstbusy_late_ack: got done,rvalid,req,err=%b want 0000", {dm_done, if_rvalid, mem_req, err_timeout}); end
        step();
        mem_ack = 1'b0;
        #1;
        n_cmp++; if ({mem_req, dm_done} !== 2'b00) begin
            n_fail++; $display("FAIL rstbusy_idle: got req,done=%b want 00", {mem_req, dm_done}); end
`ifdef ARB_PERF_CNT_EN
        n_cmp++; if ({if_wait_cnt, dm_wait_cnt} !== 64'h0) begin
            n_fail++; $display("FAIL rstbusy_perf: got if=%0d dm=%0d want 0 0", if_wait_cnt, dm_wait_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_streak();
        test_ack_on_timeout_cycle();
        test_timeout();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
